mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage_load_extend.sv | 41 ++++
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
//------------------------------------------------------------------------------
// pipe_pkg: shared bundle layouts and load one-hot indices for the pipeline.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int DW         = 32;
  localparam int REG_ADDR_W = 5;

  localparam int EXE_RF_W   = 39;
  localparam int EXE_LOAD_W = 7;
  localparam int MEM_RF_W   = 38;

  localparam int RF_RES_FROM_MEM = 38;
  localparam int RF_WE           = 37;
  localparam int RF_WADDR_MSB    = 36;
  localparam int RF_WADDR_LSB    = 32;

  localparam int LD_OFF_MSB  = 6;
  localparam int LD_OFF_LSB  = 5;
  localparam int LD_ONEHOT_W = 5;

  localparam int LD_W  = 0;
  localparam int LD_B  = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;

  typedef struct packed {
    logic                  res_from_mem;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DW-1:0]         alu_result;
  } exe_rf_t;

  typedef struct packed {
    logic [1:0]             addr_off;
    logic [LD_ONEHOT_W-1:0] ld;
  } exe_load_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
//------------------------------------------------------------------------------
// mem_stage_if: EXE->MEM->WB handshake and data-SRAM return bundle.
// Optional MEM_STAGE_BYPASS_EN adds the ID forwarding outputs.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_stage_if;
  import pipe_pkg::*;

  logic                  MEM_allow_in;
  logic                  EXE_MEM_valid;
  logic [DW-1:0]         EXE_pc;
  logic [EXE_RF_W-1:0]   EXE_rf;
  logic [EXE_LOAD_W-1:0] EXE_load;
  logic [DW-1:0]         data_sram_rdata;
  logic                  WB_allow_in;
  logic                  MEM_WB_valid;
  logic [DW-1:0]         MEM_pc;
  logic [MEM_RF_W-1:0]   MEM_rf;
`ifdef MEM_STAGE_BYPASS_EN
  logic [MEM_RF_W-1:0]   MEM_fwd;
  logic                  MEM_fwd_is_load;

  modport slave (
    input  EXE_MEM_valid, EXE_pc, EXE_rf, EXE_load, data_sram_rdata, WB_allow_in,
    output MEM_allow_in, MEM_WB_valid, MEM_pc, MEM_rf, MEM_fwd, MEM_fwd_is_load
  );
  modport master (
    output EXE_MEM_valid, EXE_pc, EXE_rf, EXE_load, data_sram_rdata, WB_allow_in,
    input  MEM_allow_in, MEM_WB_valid, MEM_pc, MEM_rf, MEM_fwd, MEM_fwd_is_load
  );
`else
  modport slave (
    input  EXE_MEM_valid, EXE_pc, EXE_rf, EXE_load, data_sram_rdata, WB_allow_in,
    output MEM_allow_in, MEM_WB_valid, MEM_pc, MEM_rf
  );
  modport master (
    output EXE_MEM_valid, EXE_pc, EXE_rf, EXE_load, data_sram_rdata, WB_allow_in,
    input  MEM_allow_in, MEM_WB_valid, MEM_pc, MEM_rf
  );
`endif

endinterface

`default_nettype wire

// File: rtl/mem_stage_load_extend.sv
//------------------------------------------------------------------------------
// load_extend: byte/halfword/word extraction with sign or zero extension.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_extend
  import pipe_pkg::*;
(
  input  logic [DW-1:0]          rdata,
  input  logic [1:0]             off,
  input  logic [LD_ONEHOT_W-1:0] ld,
  output logic [DW-1:0]          result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (off)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = '0;
    if (ld[LD_W])       result = rdata;
    else if (ld[LD_B])  result = {{24{w_byte[7]}}, w_byte};
    else if (ld[LD_BU]) result = {24'd0, w_byte};
    else if (ld[LD_H])  result = {{16{w_half[15]}}, w_half};
    else if (ld[LD_HU]) result = {16'd0, w_half};
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// mem_stage: memory-access pipeline stage with rdata hold across WB stalls.
// Optional macro MEM_STAGE_BYPASS_EN adds MEM_fwd / MEM_fwd_is_load.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);
  import pipe_pkg::*;

  generate
    if (DW != 32) begin : g_dw_check
      $error("mem_stage: only DW=32 is supported");
    end
  endgenerate

  localparam logic MEM_READY_GO = 1'b1;

  logic          r_valid;
  logic          r_first;
  logic          r_hold_vld;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_pc;
  exe_rf_t       r_rf;
  exe_load_t     r_load;

  logic          w_allow_in;
  logic          w_accept;
  logic [DW-1:0] w_load_src;
  logic [DW-1:0] w_load_result;
  logic [DW-1:0] w_wdata;

  assign w_allow_in = ~r_valid | (MEM_READY_GO & bus.WB_allow_in);
  assign w_accept   = bus.EXE_MEM_valid & w_allow_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_first    <= 1'b0;
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
      r_pc       <= '0;
      r_rf       <= '0;
      r_load     <= '0;
    end else begin
      if (w_allow_in)
        r_valid <= bus.EXE_MEM_valid;
      if (w_accept) begin
        r_pc       <= bus.EXE_pc;
        r_rf       <= exe_rf_t'(bus.EXE_rf);
        r_load     <= exe_load_t'(bus.EXE_load);
        r_first    <= 1'b1;
        r_hold_vld <= 1'b0;
      end else begin
        r_first <= 1'b0;
        // SRAM data is only presented once; keep it if WB is not taking it now.
        if (r_first && !bus.WB_allow_in && r_rf.res_from_mem) begin
          r_hold     <= bus.data_sram_rdata;
          r_hold_vld <= 1'b1;
        end
      end
    end
  end

  assign w_load_src = r_hold_vld ? r_hold : bus.data_sram_rdata;

  load_extend u_load_extend (
    .rdata  (w_load_src),
    .off    (r_load.addr_off),
    .ld     (r_load.ld),
    .result (w_load_result)
  );

  assign w_wdata = r_rf.res_from_mem ? w_load_result : r_rf.alu_result;

  assign bus.MEM_allow_in = w_allow_in;
  assign bus.MEM_WB_valid = r_valid & MEM_READY_GO;
  assign bus.MEM_pc       = r_pc;
  assign bus.MEM_rf       = {r_rf.rf_we & r_valid, r_rf.rf_waddr, w_wdata};

`ifdef MEM_STAGE_BYPASS_EN
  assign bus.MEM_fwd         = {r_rf.rf_we & r_valid, r_rf.rf_waddr, w_wdata};
  assign bus.MEM_fwd_is_load = r_valid & r_rf.res_from_mem;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// tb_mem_stage: directed self-checking bench for mem_stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(.DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic drive_idle();
    bus.EXE_MEM_valid   = 1'b0;
    bus.EXE_pc          = '0;
    bus.EXE_rf          = '0;
    bus.EXE_load        = '0;
    bus.data_sram_rdata = '0;
    bus.WB_allow_in     = 1'b1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic rfm, input logic we,
                       input logic [4:0] wa, input logic [31:0] alu,
                       input logic [1:0] off, input logic [4:0] ld);
    bus.EXE_MEM_valid = 1'b1;
    bus.EXE_pc        = pc;
    bus.EXE_rf        = {rfm, we, wa, alu};
    bus.EXE_load      = {off, ld};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk); #1;
    checks++; if (bus.MEM_WB_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.MEM_WB_valid); end
    checks++; if (bus.MEM_allow_in !== 1'b1) begin errors++; $display("FAIL rst_allow got %b exp 1", bus.MEM_allow_in); end
    checks++; if (bus.MEM_rf !== 38'd0) begin errors++; $display("FAIL rst_rf got %h exp 0", bus.MEM_rf); end
    checks++; if (bus.MEM_pc !== 32'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.MEM_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_ld_b();
    @(negedge clk);
    issue(32'h100, 1'b1, 1'b1, 5'd3, 32'h1003, 2'd3, 5'b00010);
    @(negedge clk);
    bus.EXE_MEM_valid   = 1'b0;
    bus.data_sram_rdata = 32'h80FF1234;
    #1;
    checks++; if (bus.MEM_WB_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid got %b exp 1", bus.MEM_WB_valid); end
    checks++; if (bus.MEM_rf !== {1'b1, 5'd3, 32'hFFFFFF80}) begin errors++; $display("FAIL ldb_rf got %h exp %h", bus.MEM_rf, {1'b1, 5'd3, 32'hFFFFFF80}); end
    checks++; if (bus.MEM_pc !== 32'h100) begin errors++; $display("FAIL ldb_pc got %h exp 100", bus.MEM_pc); end
`ifdef MEM_STAGE_BYPASS_EN
    checks++; if (bus.MEM_fwd !== {1'b1, 5'd3, 32'hFFFFFF80}) begin errors++; $display("FAIL ldb_fwd got %h", bus.MEM_fwd); end
    checks++; if (bus.MEM_fwd_is_load !== 1'b1) begin errors++; $display("FAIL ldb_fwd_is_load got %b exp 1", bus.MEM_fwd_is_load); end
`endif
    @(negedge clk); #1;
    checks++; if (bus.MEM_WB_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b exp 0", bus.MEM_WB_valid); end
    checks++; if (bus.MEM_rf[37] !== 1'b0) begin errors++; $display("FAIL drop_we got %b exp 0", bus.MEM_rf[37]); end
  endtask

  task automatic test_ld_h();
    @(negedge clk);
    issue(32'h200, 1'b1, 1'b1, 5'd8, 32'h0, 2'd2, 5'b10000);
    @(negedge clk);
    issue(32'h204, 1'b1, 1'b1, 5'd9, 32'h0, 2'd0, 5'b00100);
    bus.data_sram_rdata = 32'h8001ABCD;
    #1;
    checks++; if (bus.MEM_rf[31:0] !== 32'h00008001) begin errors++; $display("FAIL ldhu_data got %h exp 00008001", bus.MEM_rf[31:0]); end
    @(negedge clk);
    bus.EXE_MEM_valid   = 1'b0;
    bus.data_sram_rdata = 32'h8001ABCD;
    #1;
    checks++; if (bus.MEM_rf[31:0] !== 32'hFFFFABCD) begin errors++; $display("FAIL ldh_data got %h exp FFFFABCD", bus.MEM_rf[31:0]); end
    checks++; if (bus.MEM_pc !== 32'h204) begin errors++; $display("FAIL ldh_pc got %h exp 204", bus.MEM_pc); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    issue(32'h300, 1'b1, 1'b1, 5'd7, 32'hCAFE, 2'd2, 5'b00001);
    @(negedge clk);
    bus.EXE_MEM_valid = 1'b0;
    bus.WB_allow_in   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data_sram_rdata = (i == 0) ? 32'h12345678 : 32'hDEADBEEF;
      #1;
      checks++; if (bus.MEM_allow_in !== 1'b0) begin errors++; $display("FAIL stall_allow[%0d] got %b exp 0", i, bus.MEM_allow_in); end
      checks++; if (bus.MEM_WB_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, bus.MEM_WB_valid); end
      checks++; if (bus.MEM_rf[31:0] !== 32'h12345678) begin errors++; $display("FAIL stall_data[%0d] got %h exp 12345678", i, bus.MEM_rf[31:0]); end
      @(negedge clk);
    end
    bus.WB_allow_in     = 1'b1;
    bus.data_sram_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.MEM_allow_in !== 1'b1) begin errors++; $display("FAIL rel_allow got %b exp 1", bus.MEM_allow_in); end
    checks++; if (bus.MEM_rf !== {1'b1, 5'd7, 32'h12345678}) begin errors++; $display("FAIL rel_rf got %h exp %h", bus.MEM_rf, {1'b1, 5'd7, 32'h12345678}); end
    @(negedge clk); #1;
    checks++; if (bus.MEM_WB_valid !== 1'b0) begin errors++; $display("FAIL rel_drop got %b exp 0", bus.MEM_WB_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(32'h400, 1'b0, 1'b1, 5'd4, 32'h5, 2'd0, 5'b00000);
    @(negedge clk);
    issue(32'h404, 1'b1, 1'b1, 5'd5, 32'h77, 2'd1, 5'b01000);
    bus.data_sram_rdata = 32'hFFFFFFFF;
    #1;
    checks++; if (bus.MEM_rf !== {1'b1, 5'd4, 32'h5}) begin errors++; $display("FAIL b2b_add got %h exp %h", bus.MEM_rf, {1'b1, 5'd4, 32'h5}); end
    checks++; if (bus.MEM_allow_in !== 1'b1) begin errors++; $display("FAIL b2b_allow0 got %b exp 1", bus.MEM_allow_in); end
    @(negedge clk);
    bus.EXE_MEM_valid   = 1'b0;
    bus.data_sram_rdata = 32'h0000A500;
    #1;
    checks++; if (bus.MEM_rf !== {1'b1, 5'd5, 32'hA5}) begin errors++; $display("FAIL b2b_ldbu got %h exp %h", bus.MEM_rf, {1'b1, 5'd5, 32'hA5}); end
    checks++; if (bus.MEM_WB_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", bus.MEM_WB_valid); end
    checks++; if (bus.MEM_allow_in !== 1'b1) begin errors++; $display("FAIL b2b_allow1 got %b exp 1", bus.MEM_allow_in); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    issue(32'h500, 1'b1, 1'b1, 5'd10, 32'h0, 2'd0, 5'b00001);
    @(negedge clk);
    bus.EXE_MEM_valid   = 1'b0;
    bus.WB_allow_in     = 1'b0;
    bus.data_sram_rdata = 32'h11111111;
    @(negedge clk);
    bus.data_sram_rdata = 32'h99999999;
    #1;
    checks++; if (bus.MEM_rf[31:0] !== 32'h11111111) begin errors++; $display("FAIL hold_data got %h exp 11111111", bus.MEM_rf[31:0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.MEM_WB_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", bus.MEM_WB_valid); end
    checks++; if (bus.MEM_allow_in !== 1'b1) begin errors++; $display("FAIL arst_allow got %b exp 1", bus.MEM_allow_in); end
    checks++; if (bus.MEM_rf !== 38'd0) begin errors++; $display("FAIL arst_rf got %h exp 0", bus.MEM_rf); end
    #1;
    rst_n           = 1'b1;
    bus.WB_allow_in = 1'b1;
    @(negedge clk);
    issue(32'h600, 1'b1, 1'b1, 5'd11, 32'h0, 2'd0, 5'b00001);
    @(negedge clk);
    bus.EXE_MEM_valid   = 1'b0;
    bus.data_sram_rdata = 32'h22222222;
    #1;
    checks++; if (bus.MEM_rf !== {1'b1, 5'd11, 32'h22222222}) begin errors++; $display("FAIL post_rst_rf got %h exp %h", bus.MEM_rf, {1'b1, 5'd11, 32'h22222222}); end
  endtask

  initial begin
    test_reset();
    test_ld_b();
    test_ld_h();
    test_stall();
    test_back_to_back();
    test_reset_mid_stall();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
